// File: rtl/rob_multi.sv
// Parametrised reorder buffer: in-order tag allocation, completion from NUM_BUS
// writeback buses, up to RETIRE_W in-order retirements per cycle, precise flush.
module rob_multi #(
    parameter int  DEPTH      = 16,
    parameter int  PREG_WIDTH = 6,
    parameter int  PC_WIDTH   = 12,
    parameter int  NUM_BUS    = 3,
    parameter int  RETIRE_W   = 2,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [PREG_WIDTH-1:0]          disp_rd,
    input  logic [PREG_WIDTH-1:0]          disp_rd_old,
    input  logic                           disp_has_rd,
    input  logic [PC_WIDTH-1:0]            disp_pc,
    output logic [IDX_W-1:0]               rob_num,
    input  logic [NUM_BUS-1:0]             wb_valid,
    input  logic [NUM_BUS*IDX_W-1:0]       wb_tag,
    input  logic [NUM_BUS-1:0]             wb_exc,
    output logic [RETIRE_W-1:0]            retire_valid,
    output logic [RETIRE_W*PREG_WIDTH-1:0] retire_rd,
    output logic [RETIRE_W*PREG_WIDTH-1:0] retire_rd_old,
    output logic [RETIRE_W-1:0]            retire_has_rd,
    output logic [RETIRE_W*PC_WIDTH-1:0]   retire_pc,
    output logic                           flush_valid,
    output logic [PC_WIDTH-1:0]            flush_pc,
    output logic [IDX_W:0]                 count,
    output logic                           empty
);

    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_done;
    logic [DEPTH-1:0]      ent_exc;
    logic [DEPTH-1:0]      ent_has_rd;
    logic [PREG_WIDTH-1:0] ent_rd     [DEPTH];
    logic [PREG_WIDTH-1:0] ent_rd_old [DEPTH];
    logic [PC_WIDTH-1:0]   ent_pc     [DEPTH];

    logic [IDX_W:0]        head;
    logic [IDX_W:0]        tail;
    logic [IDX_W:0]        occ;
    logic [IDX_W-1:0]      head_idx;
    logic [IDX_W-1:0]      tail_idx;
    logic                  accept;
    logic                  flush;

    logic [DEPTH-1:0]      wb_hit;
    logic [DEPTH-1:0]      wb_exc_hit;
    logic [RETIRE_W-1:0]   ret_vec;
    logic [IDX_W-1:0]      slot_idx [RETIRE_W];
    logic [IDX_W:0]        n_ret;
    logic                  chain;

    assign head_idx   = head[IDX_W-1:0];
    assign tail_idx   = tail[IDX_W-1:0];
    assign count      = occ;
    assign empty      = (occ == '0);
    assign disp_ready = (occ < (IDX_W+1)'(DEPTH));
    assign rob_num    = tail_idx;
    assign accept     = disp_valid && disp_ready;
    assign flush      = ent_valid[head_idx] && ent_done[head_idx] && ent_exc[head_idx];

    // Per-entry OR of all buses, so duplicate tags merge their exception bits.
    always_comb begin
        wb_hit     = '0;
        wb_exc_hit = '0;
        for (int unsigned b = 0; b < NUM_BUS; b++) begin
            if (wb_valid[b]) begin
                wb_hit[wb_tag[b*IDX_W +: IDX_W]]     = 1'b1;
                wb_exc_hit[wb_tag[b*IDX_W +: IDX_W]] = wb_exc_hit[wb_tag[b*IDX_W +: IDX_W]] | wb_exc[b];
            end
        end
    end

    always_comb begin
        ret_vec = '0;
        n_ret   = '0;
        chain   = 1'b1;
        for (int unsigned k = 0; k < RETIRE_W; k++) begin
            slot_idx[k] = head_idx + IDX_W'(k);
            chain       = chain && ent_valid[slot_idx[k]] && ent_done[slot_idx[k]]
                          && !ent_exc[slot_idx[k]];
            ret_vec[k]  = chain;
            n_ret       = n_ret + (IDX_W+1)'(chain);
        end
    end

    // Status bits and pointers; later assignments (retire, dispatch) override writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head          <= '0;
            tail          <= '0;
            occ           <= '0;
            ent_valid     <= '0;
            ent_done      <= '0;
            ent_exc       <= '0;
            retire_valid  <= '0;
            retire_rd     <= '0;
            retire_rd_old <= '0;
            retire_has_rd <= '0;
            retire_pc     <= '0;
            flush_valid   <= 1'b0;
            flush_pc      <= '0;
        end else begin
            flush_valid   <= flush;
            retire_valid  <= '0;
            retire_rd     <= '0;
            retire_rd_old <= '0;
            retire_has_rd <= '0;
            retire_pc     <= '0;
            if (flush) begin
                flush_pc  <= ent_pc[head_idx];
                ent_valid <= '0;
                ent_done  <= '0;
                ent_exc   <= '0;
                head      <= '0;
                tail      <= '0;
                occ       <= '0;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (ent_valid[i] && wb_hit[i]) begin
                        ent_done[i] <= 1'b1;
                        ent_exc[i]  <= ent_exc[i] | wb_exc_hit[i];
                    end
                end
                for (int unsigned k = 0; k < RETIRE_W; k++) begin
                    if (ret_vec[k]) begin
                        ent_valid[slot_idx[k]] <= 1'b0;
                        ent_done[slot_idx[k]]  <= 1'b0;
                        ent_exc[slot_idx[k]]   <= 1'b0;
                        retire_valid[k]        <= 1'b1;
                        retire_has_rd[k]       <= ent_has_rd[slot_idx[k]];
                        retire_rd[k*PREG_WIDTH +: PREG_WIDTH]     <= ent_rd[slot_idx[k]];
                        retire_rd_old[k*PREG_WIDTH +: PREG_WIDTH] <= ent_rd_old[slot_idx[k]];
                        retire_pc[k*PC_WIDTH +: PC_WIDTH]         <= ent_pc[slot_idx[k]];
                    end
                end
                if (accept) begin
                    ent_valid[tail_idx] <= 1'b1;
                    ent_done[tail_idx]  <= 1'b0;
                    ent_exc[tail_idx]   <= 1'b0;
                    tail                <= tail + 1'b1;
                end
                head <= head + n_ret;
                occ  <= occ + (IDX_W+1)'(accept) - n_ret;
            end
        end
    end

    // Payload is only read for valid entries, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept && !flush) begin
            ent_rd[tail_idx]     <= disp_rd;
            ent_rd_old[tail_idx] <= disp_rd_old;
            ent_has_rd[tail_idx] <= disp_has_rd;
            ent_pc[tail_idx]     <= disp_pc;
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
// Bench for rob_multi: directed table, hand sequences and random traffic, all
// compared against a queue-based model of the reorder buffer.
module tb_rob_multi;

    localparam int DEPTH = 16;
    localparam int PW    = 6;
    localparam int CW    = 12;
    localparam int NB    = 3;
    localparam int RW    = 2;
    localparam int IW    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_valid;
    logic              disp_ready;
    logic [PW-1:0]     disp_rd;
    logic [PW-1:0]     disp_rd_old;
    logic              disp_has_rd;
    logic [CW-1:0]     disp_pc;
    logic [IW-1:0]     rob_num;
    logic [NB-1:0]     wb_valid;
    logic [NB*IW-1:0]  wb_tag;
    logic [NB-1:0]     wb_exc;
    logic [RW-1:0]     retire_valid;
    logic [RW*PW-1:0]  retire_rd;
    logic [RW*PW-1:0]  retire_rd_old;
    logic [RW-1:0]     retire_has_rd;
    logic [RW*CW-1:0]  retire_pc;
    logic              flush_valid;
    logic [CW-1:0]     flush_pc;
    logic [IW:0]       count;
    logic              empty;

    rob_multi #(
        .DEPTH(DEPTH), .PREG_WIDTH(PW), .PC_WIDTH(CW), .NUM_BUS(NB), .RETIRE_W(RW)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_rd(disp_rd), .disp_rd_old(disp_rd_old), .disp_has_rd(disp_has_rd),
        .disp_pc(disp_pc), .rob_num(rob_num),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_exc(wb_exc),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_rd_old(retire_rd_old),
        .retire_has_rd(retire_has_rd), .retire_pc(retire_pc),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          tag;
        logic [PW-1:0] rd;
        logic [PW-1:0] rd_old;
        logic        has_rd;
        logic [CW-1:0] pc;
        bit          done;
        bit          exc;
    } ent_t;

    ent_t q[$];
    int   m_tail = 0;

    logic [RW-1:0]    exp_rv;
    logic [RW*PW-1:0] exp_rd;
    logic [RW*PW-1:0] exp_rdo;
    logic [RW-1:0]    exp_hrd;
    logic [RW*CW-1:0] exp_pc;
    bit               exp_flush;
    logic [CW-1:0]    exp_fpc;
    int               exp_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tail = 0;
    endtask

    // Model of one clock edge from the ROB rules: flush, else retire the done
    // non-excepting prefix, apply completions, then accept dispatch if not full.
    task automatic model_step();
        int sz;
        int nr;
        sz        = q.size();
        nr        = 0;
        exp_rv    = '0;
        exp_rd    = '0;
        exp_rdo   = '0;
        exp_hrd   = '0;
        exp_pc    = '0;
        exp_flush = 1'b0;
        if (sz > 0 && q[0].done && q[0].exc) begin
            exp_flush = 1'b1;
            exp_fpc   = q[0].pc;
            q.delete();
            m_tail = 0;
        end else begin
            while (nr < RW && nr < sz && q[nr].done && !q[nr].exc) begin
                exp_rv[nr]             = 1'b1;
                exp_rd[nr*PW +: PW]    = q[nr].rd;
                exp_rdo[nr*PW +: PW]   = q[nr].rd_old;
                exp_hrd[nr]            = q[nr].has_rd;
                exp_pc[nr*CW +: CW]    = q[nr].pc;
                nr++;
            end
            for (int b = 0; b < NB; b++) begin
                if (wb_valid[b]) begin
                    for (int i = 0; i < q.size(); i++) begin
                        if (q[i].tag == int'(wb_tag[b*IW +: IW])) begin
                            ent_t e = q[i];
                            e.done = 1'b1;
                            e.exc  = e.exc | wb_exc[b];
                            q[i]   = e;
                        end
                    end
                end
            end
            repeat (nr) void'(q.pop_front());
            if (disp_valid && sz < DEPTH) begin
                ent_t e;
                e.tag    = m_tail;
                e.rd     = disp_rd;
                e.rd_old = disp_rd_old;
                e.has_rd = disp_has_rd;
                e.pc     = disp_pc;
                e.done   = 1'b0;
                e.exc    = 1'b0;
                q.push_back(e);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        exp_cnt = q.size();
    endtask

    task automatic step();
        chk("rob_num", rob_num, m_tail);
        model_step();
        @(posedge clk);
        #1;
        chk("retire_valid", retire_valid, exp_rv);
        chk("retire_rd", retire_rd, exp_rd);
        chk("retire_rd_old", retire_rd_old, exp_rdo);
        chk("retire_has_rd", retire_has_rd, exp_hrd);
        chk("retire_pc", retire_pc, exp_pc);
        chk("flush_valid", flush_valid, exp_flush);
        if (exp_flush) chk("flush_pc", flush_pc, exp_fpc);
        chk("count", count, exp_cnt);
        chk("empty", empty, exp_cnt == 0);
        chk("disp_ready", disp_ready, exp_cnt < DEPTH);
    endtask

    task automatic set_idle();
        disp_valid  = 1'b0;
        disp_rd     = '0;
        disp_rd_old = '0;
        disp_has_rd = 1'b0;
        disp_pc     = '0;
        wb_valid    = '0;
        wb_tag      = '0;
        wb_exc      = '0;
    endtask

    task automatic set_disp(input logic [CW-1:0] pc);
        disp_valid  = 1'b1;
        disp_pc     = pc;
        disp_rd     = pc[PW-1:0];
        disp_rd_old = ~pc[PW-1:0];
        disp_has_rd = pc[2];
    endtask

    task automatic set_wb(input int b, input int tag, input bit exc);
        wb_valid[b]          = 1'b1;
        wb_tag[b*IW +: IW]   = IW'(tag);
        wb_exc[b]            = exc;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          rst_b;
        bit          dv;
        logic [CW-1:0] pc;
        logic [NB-1:0] wv;
        int          t0, t1, t2;
        logic [NB-1:0] we;
        int          num;
        logic [RW-1:0] rv;
        int          cnt;
        bit          fl;
        logic [CW-1:0] fpc;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        logic [CW-1:0] pc5;

        // Out-of-order completion, then exception with flush.
        tbl[0]  = '{1, 1, 12'h100, 3'b000, 0, 0, 0, 3'b000, 0, 2'b00, 1, 0, 12'h000};
        tbl[1]  = '{0, 1, 12'h104, 3'b000, 0, 0, 0, 3'b000, 1, 2'b00, 2, 0, 12'h000};
        tbl[2]  = '{0, 1, 12'h108, 3'b000, 0, 0, 0, 3'b000, 2, 2'b00, 3, 0, 12'h000};
        tbl[3]  = '{0, 1, 12'h10C, 3'b000, 0, 0, 0, 3'b000, 3, 2'b00, 4, 0, 12'h000};
        tbl[4]  = '{0, 0, 12'h000, 3'b001, 3, 0, 0, 3'b000, 4, 2'b00, 4, 0, 12'h000};
        tbl[5]  = '{0, 0, 12'h000, 3'b011, 2, 1, 0, 3'b000, 4, 2'b00, 4, 0, 12'h000};
        tbl[6]  = '{0, 0, 12'h000, 3'b001, 0, 0, 0, 3'b000, 4, 2'b00, 4, 0, 12'h000};
        tbl[7]  = '{0, 0, 12'h000, 3'b000, 0, 0, 0, 3'b000, 4, 2'b11, 2, 0, 12'h000};
        tbl[8]  = '{0, 0, 12'h000, 3'b000, 0, 0, 0, 3'b000, 4, 2'b11, 0, 0, 12'h000};
        tbl[9]  = '{1, 1, 12'h200, 3'b000, 0, 0, 0, 3'b000, 0, 2'b00, 1, 0, 12'h000};
        tbl[10] = '{0, 1, 12'h204, 3'b000, 0, 0, 0, 3'b000, 1, 2'b00, 2, 0, 12'h000};
        tbl[11] = '{0, 1, 12'h208, 3'b000, 0, 0, 0, 3'b000, 2, 2'b00, 3, 0, 12'h000};
        tbl[12] = '{0, 0, 12'h000, 3'b011, 0, 1, 0, 3'b010, 3, 2'b00, 3, 0, 12'h000};
        tbl[13] = '{0, 0, 12'h000, 3'b000, 0, 0, 0, 3'b000, 3, 2'b01, 2, 0, 12'h000};
        tbl[14] = '{0, 1, 12'h300, 3'b000, 0, 0, 0, 3'b000, 3, 2'b00, 0, 1, 12'h204};
        tbl[15] = '{0, 1, 12'h304, 3'b000, 0, 0, 0, 3'b000, 0, 2'b00, 1, 0, 12'h000};

        set_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_ready", disp_ready, 1);
        chk("reset_retire_valid", retire_valid, 0);
        chk("reset_flush", flush_valid, 0);
        rst = 1'b1;
        model_reset();

        for (int r = 0; r < 16; r++) begin
            set_idle();
            if (tbl[r].rst_b) do_reset();
            if (tbl[r].dv) set_disp(tbl[r].pc);
            if (tbl[r].wv[0]) set_wb(0, tbl[r].t0, tbl[r].we[0]);
            if (tbl[r].wv[1]) set_wb(1, tbl[r].t1, tbl[r].we[1]);
            if (tbl[r].wv[2]) set_wb(2, tbl[r].t2, tbl[r].we[2]);
            chk($sformatf("tbl%0d_num", r), rob_num, tbl[r].num);
            step();
            chk($sformatf("tbl%0d_rv", r), retire_valid, tbl[r].rv);
            chk($sformatf("tbl%0d_cnt", r), count, tbl[r].cnt);
            chk($sformatf("tbl%0d_flush", r), flush_valid, tbl[r].fl);
            if (tbl[r].fl) chk($sformatf("tbl%0d_fpc", r), flush_pc, tbl[r].fpc);
        end

        // Reset asserted mid-traffic with 5 entries valid.
        set_idle();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_disp(CW'(12'h400 + 4 * i));
            step();
        end
        set_idle();
        chk("pre_reset_count", count, 5);
        rst = 1'b0;
        #1;
        chk("async_reset_count", count, 0);
        chk("async_reset_empty", empty, 1);
        chk("async_reset_ready", disp_ready, 1);
        chk("async_reset_num", rob_num, 0);
        chk("async_reset_rv", retire_valid, 0);
        chk("async_reset_flush", flush_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        set_disp(12'h500);
        chk("post_reset_num", rob_num, 0);
        step();

        // Fill to full, drop the 17th, then wrap-around.
        set_idle();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_disp(CW'($urandom));
            chk("fill_num", rob_num, (i < 16) ? i : 0);
            step();
            if (i == 15) begin
                chk("full_count", count, 16);
                chk("full_ready", disp_ready, 0);
            end
        end
        chk("drop_count", count, 16);
        set_idle();
        for (int c = 0; c < 5; c++) begin
            set_idle();
            for (int b = 0; b < NB; b++)
                if (3 * c + b <= 13) set_wb(b, 3 * c + b, 1'b0);
            step();
        end
        set_idle();
        for (int c = 0; c < 20 && count > 2; c++) step();
        chk("wrap_count14", count, 2);
        for (int i = 0; i < 4; i++) begin
            set_idle();
            set_disp(CW'(12'h600 + i));
            chk("wrap_num", rob_num, i);
            step();
        end
        chk("wrap_count6", count, 6);
        set_idle();
        set_wb(0, 14, 1'b0);
        set_wb(1, 15, 1'b0);
        set_wb(2, 0, 1'b0);
        step();
        set_idle();
        set_wb(0, 1, 1'b0);
        set_wb(1, 2, 1'b0);
        set_wb(2, 3, 1'b0);
        step();
        set_idle();
        for (int c = 0; c < 10 && count != 0; c++) step();
        chk("wrap_drain", count, 0);

        // Three buses naming the same tag; only bus 2 reports the exception.
        do_reset();
        pc5 = '0;
        for (int i = 0; i < 6; i++) begin
            set_idle();
            set_disp(CW'($urandom));
            if (i == 5) pc5 = disp_pc;
            step();
        end
        set_idle();
        set_wb(0, 5, 1'b0);
        set_wb(1, 5, 1'b0);
        set_wb(2, 5, 1'b1);
        step();
        set_idle();
        set_wb(0, 0, 1'b0);
        set_wb(1, 1, 1'b0);
        set_wb(2, 2, 1'b0);
        step();
        set_idle();
        set_wb(0, 3, 1'b0);
        set_wb(1, 4, 1'b0);
        step();
        set_idle();
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            step();
            if (flush_valid) begin
                seen = 1;
                chk("simul_flush_pc", flush_pc, pc5);
            end
        end
        chk("simul_flush_seen", seen, 1);
        chk("simul_count", count, 0);

        // Random traffic: a dispatch-heavy phase, then a completion-heavy one.
        do_reset();
        for (int c = 0; c < 1600; c++) begin
            int dpct;
            int wpct;
            dpct = (c < 800) ? 85 : 50;
            wpct = (c < 800) ? 25 : 55;
            set_idle();
            if ($urandom_range(0, 99) < dpct) begin
                disp_valid  = 1'b1;
                disp_pc     = CW'($urandom);
                disp_rd     = PW'($urandom);
                disp_rd_old = PW'($urandom);
                disp_has_rd = 1'($urandom);
            end
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 99) < wpct) begin
                    int t;
                    if (q.size() > 0 && $urandom_range(0, 9) != 0)
                        t = q[$urandom_range(0, q.size() - 1)].tag;
                    else
                        t = $urandom_range(0, DEPTH - 1);
                    set_wb(b, t, $urandom_range(0, 99) < 2);
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
